text_renderer: RTL and testbench

- Initiator side of the per-character draw handshake: walks a buffered ASCII string and drives one character renderer, one glyph at a time.
- Computes each glyph origin, advances the pen, wraps lines and stops at the bottom of the screen.
- Sits between the UI/layout logic, which loads strings, and the character renderer, which feeds the square/pixel path.

---
 rtl/text_renderer_pkg.sv | 53 +++++
 rtl/text_buffer.sv | 32 +++
 rtl/text_renderer.sv | 169 ++++++++++++++++
 tb/tb_text_renderer.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/text_renderer_pkg.sv
// Shared constants, types and helpers for the text renderer.
// Build option: TEXT_RENDERER_SKIP_SPACE_EN (spaces advance the pen without a handshake).
package text_renderer_pkg;

    localparam int CHAR_W      = 8;
    localparam int X_W         = 10;
    localparam int Y_W         = 9;
    localparam int SIZE_W      = 4;
    localparam int FONT_WIDTH  = 5;
    localparam int FONT_HEIGHT = 7;
    localparam int MAX_CHARS   = 32;
    localparam int SCREEN_W    = 640;
    localparam int SCREEN_H    = 480;

    localparam int ADDR_W = $clog2(MAX_CHARS);
    localparam int LEN_W  = ADDR_W + 1;

    localparam logic [CHAR_W-1:0] ASCII_NL = 8'h0A;
    localparam logic [CHAR_W-1:0] ASCII_SP = 8'h20;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECIDE,
        S_SETUP,
        S_DRAW,
        S_RELEASE,
        S_NEXT,
        S_DONE
    } state_t;

    // Job parameters captured when a start is accepted.
    typedef struct packed {
        logic [LEN_W-1:0]  length;
        logic [X_W-1:0]    origin_x;
        logic [SIZE_W-1:0] size;
    } job_t;

    function automatic logic [X_W-1:0] scale_x(
        input logic [SIZE_W-1:0] s,
        input int unsigned       k
    );
        return X_W'(s) * X_W'(k);
    endfunction

    function automatic logic [Y_W-1:0] scale_y(
        input logic [SIZE_W-1:0] s,
        input int unsigned       k
    );
        return Y_W'(s) * Y_W'(k);
    endfunction

endpackage

// File: rtl/text_buffer.sv
// String buffer: one write port, one registered read port.
// Read data holds its value until the next read enable.
module text_buffer
    import text_renderer_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [CHAR_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [CHAR_W-1:0] rd_data
);

    logic [CHAR_W-1:0] mem [MAX_CHARS];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/text_renderer.sv
// Walks the string buffer and drives the character renderer one glyph at a time.
// Build option: TEXT_RENDERER_SKIP_SPACE_EN (spaces advance the pen without a handshake).
module text_renderer
    import text_renderer_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [CHAR_W-1:0] wr_data,
    input  logic              start,
    input  logic [LEN_W-1:0]  length,
    input  logic [X_W-1:0]    origin_x,
    input  logic [Y_W-1:0]    origin_y,
    input  logic [SIZE_W-1:0] size,
    output logic              busy,
    output logic              done,
    output logic              clipped,
    output logic [CHAR_W-1:0] char_code,
    output logic [X_W-1:0]    char_x,
    output logic [Y_W-1:0]    char_y,
    output logic [SIZE_W-1:0] char_size,
    output logic              char_enable,
    input  logic              char_finished
);

    localparam logic [X_W:0] EDGE_X = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0] EDGE_Y = (Y_W+1)'(SCREEN_H);

    state_t            state;
    job_t              job;
    logic [X_W-1:0]    pen_x;
    logic [Y_W-1:0]    pen_y;
    logic [LEN_W-1:0]  index;
    logic [CHAR_W-1:0] rd_data;

    logic [X_W-1:0] advance;
    logic [X_W-1:0] glyph_w;
    logic [Y_W-1:0] line_step;
    logic [Y_W-1:0] glyph_h;
    logic           wrap_hit;
    logic           clip_hit;
    logic           is_nl;
    logic           is_skip;

    assign advance   = scale_x(job.size, FONT_WIDTH + 1);
    assign glyph_w   = scale_x(job.size, FONT_WIDTH);
    assign line_step = scale_y(job.size, FONT_HEIGHT + 1);
    assign glyph_h   = scale_y(job.size, FONT_HEIGHT);

    // One extra bit so the right/bottom edge tests never wrap.
    assign wrap_hit = ({1'b0, pen_x} + {1'b0, glyph_w}) > EDGE_X;
    assign clip_hit = ({1'b0, pen_y} + {1'b0, glyph_h}) > EDGE_Y;
    assign is_nl    = (rd_data == ASCII_NL);

`ifdef TEXT_RENDERER_SKIP_SPACE_EN
    assign is_skip = (rd_data == ASCII_SP);
`else
    assign is_skip = 1'b0;
`endif

    text_buffer u_buf (
        .clock   (clock),
        .reset_n (reset_n),
        .wr_en   (wr_en && !busy),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (state == S_FETCH),
        .rd_addr (index[ADDR_W-1:0]),
        .rd_data (rd_data)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            job         <= '0;
            pen_x       <= '0;
            pen_y       <= '0;
            index       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            clipped     <= 1'b0;
            char_code   <= '0;
            char_x      <= '0;
            char_y      <= '0;
            char_size   <= '0;
            char_enable <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        job     <= '{length, origin_x, size};
                        pen_x   <= origin_x;
                        pen_y   <= origin_y;
                        index   <= '0;
                        clipped <= 1'b0;
                        if (length == '0 || size == '0) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= S_FETCH;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end
                    end
                end
                S_FETCH: begin
                    state <= S_DECIDE;
                end
                S_DECIDE: begin
                    if (is_nl) begin
                        pen_x <= job.origin_x;
                        pen_y <= pen_y + line_step;
                        index <= index + 1'b1;
                        state <= S_NEXT;
                    end else if (wrap_hit) begin
                        // Same character is re-tested on the new line.
                        pen_x <= job.origin_x;
                        pen_y <= pen_y + line_step;
                    end else if (clip_hit) begin
                        clipped <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= S_DONE;
                    end else if (is_skip) begin
                        pen_x <= pen_x + advance;
                        index <= index + 1'b1;
                        state <= S_NEXT;
                    end else begin
                        char_code <= rd_data;
                        char_x    <= pen_x;
                        char_y    <= pen_y;
                        char_size <= job.size;
                        state     <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    char_enable <= 1'b1;
                    state       <= S_DRAW;
                end
                S_DRAW: begin
                    if (char_finished) begin
                        char_enable <= 1'b0;
                        pen_x       <= pen_x + advance;
                        index       <= index + 1'b1;
                        state       <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    state <= S_NEXT;
                end
                S_NEXT: begin
                    if (index == job.length) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        state <= S_FETCH;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_text_renderer.sv
// Self-checking bench: randomized strings against a behavioural layout model.
// A small renderer model answers the draw handshake and records every glyph.
`timescale 1ns/1ps
module tb_text_renderer;
    import text_renderer_pkg::*;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [CHAR_W-1:0] wr_data = '0;
    logic              start = 1'b0;
    logic [LEN_W-1:0]  length = '0;
    logic [X_W-1:0]    origin_x = '0;
    logic [Y_W-1:0]    origin_y = '0;
    logic [SIZE_W-1:0] size = '0;
    logic              busy;
    logic              done;
    logic              clipped;
    logic [CHAR_W-1:0] char_code;
    logic [X_W-1:0]    char_x;
    logic [Y_W-1:0]    char_y;
    logic [SIZE_W-1:0] char_size;
    logic              char_enable;
    logic              char_finished = 1'b0;

    text_renderer dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .start         (start),
        .length        (length),
        .origin_x      (origin_x),
        .origin_y      (origin_y),
        .size          (size),
        .busy          (busy),
        .done          (done),
        .clipped       (clipped),
        .char_code     (char_code),
        .char_x        (char_x),
        .char_y        (char_y),
        .char_size     (char_size),
        .char_enable   (char_enable),
        .char_finished (char_finished)
    );

    always #5 clock = ~clock;

    typedef struct {
        int code;
        int x;
        int y;
        int s;
    } glyph_t;

    glyph_t    seen_q[$];
    glyph_t    want_q[$];
    logic [7:0] shadow [MAX_CHARS];
    bit        want_clip;
    int        rend_lat = 3;
    int        total = 0;
    int        bad = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Renderer model: latches origin on enable rise, finishes rend_lat cycles later.
    initial begin : renderer
        int         cnt;
        bit         prev_en;
        logic [30:0] now_pack;
        logic [30:0] last_pack;
        logic [30:0] rise_pack;
        glyph_t     g;
        cnt = 0;
        prev_en = 1'b0;
        last_pack = '0;
        rise_pack = '0;
        forever begin
            @(negedge clock);
            now_pack = {char_code, char_x, char_y, char_size};
            if (!reset_n) begin
                char_finished = 1'b0;
                cnt = 0;
                prev_en = 1'b0;
            end else begin
                if (char_enable && !prev_en) begin
                    check("setup_stable", longint'(now_pack), longint'(last_pack));
                    rise_pack = now_pack;
                    g.code = int'(char_code);
                    g.x = int'(char_x);
                    g.y = int'(char_y);
                    g.s = int'(char_size);
                    seen_q.push_back(g);
                    cnt = 0;
                end
                if (char_enable) begin
                    cnt++;
                    if (cnt == rend_lat)
                        check("hold", longint'(now_pack), longint'(rise_pack));
                    if (cnt >= rend_lat)
                        char_finished = 1'b1;
                end else begin
                    char_finished = 1'b0;
                end
                prev_en = char_enable;
            end
            last_pack = now_pack;
        end
    end

    // Layout reference: plain pen arithmetic over the shadow string.
    function automatic void model(input int len, input int ox, input int oy, input int sz);
        int px;
        int py;
        int i;
        int c;
        int guard;
        glyph_t g;
        want_q.delete();
        want_clip = 1'b0;
        if (len == 0 || sz == 0) return;
        px = ox;
        py = oy;
        i = 0;
        guard = 0;
        while (i < len && guard < 1000) begin
            guard++;
            c = int'(shadow[i]);
            if (c == 10) begin
                px = ox;
                py = (py + 8 * sz) % 512;
                i++;
            end else if (px + 5 * sz > 640) begin
                px = ox;
                py = (py + 8 * sz) % 512;
            end else if (py + 7 * sz > 480) begin
                want_clip = 1'b1;
                break;
`ifdef TEXT_RENDERER_SKIP_SPACE_EN
            end else if (c == 32) begin
                px = (px + 6 * sz) % 1024;
                i++;
`endif
            end else begin
                g.code = c;
                g.x = px;
                g.y = py;
                g.s = sz;
                want_q.push_back(g);
                px = (px + 6 * sz) % 1024;
                i++;
            end
        end
    endfunction

    task automatic write_shadow(input int len);
        for (int k = 0; k < len; k++) begin
            @(negedge clock);
            wr_en = 1'b1;
            wr_addr = ADDR_W'(k);
            wr_data = shadow[k];
        end
        @(negedge clock);
        wr_en = 1'b0;
    endtask

    task automatic load(input string s);
        for (int k = 0; k < s.len(); k++)
            shadow[k] = s[k];
        write_shadow(s.len());
    endtask

    task automatic run_job(input string tag, input int len, input int ox,
                           input int oy, input int sz, input int lat,
                           input bit poke);
        int n;
        model(len, ox, oy, sz);
        seen_q.delete();
        rend_lat = lat;
        @(negedge clock);
        length = LEN_W'(len);
        origin_x = X_W'(ox);
        origin_y = Y_W'(oy);
        size = SIZE_W'(sz);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        if (len == 0 || sz == 0)
            check({tag, "_quick"}, longint'({busy, done}), 1);
        else
            check({tag, "_busy"}, longint'(busy), 1);
        n = 0;
        while (!done && n < 5000) begin
            if (poke) begin
                wr_en = busy;
                wr_addr = ADDR_W'($urandom);
                wr_data = CHAR_W'($urandom);
            end
            @(negedge clock);
            n++;
        end
        wr_en = 1'b0;
        check({tag, "_done"}, longint'(done), 1);
        check({tag, "_idle"}, longint'(busy), 0);
        check({tag, "_clip"}, longint'(clipped), longint'(want_clip));
        check({tag, "_count"}, seen_q.size(), want_q.size());
        for (int k = 0; k < want_q.size() && k < seen_q.size(); k++) begin
            check({tag, "_code"}, seen_q[k].code, want_q[k].code);
            check({tag, "_x"}, seen_q[k].x, want_q[k].x);
            check({tag, "_y"}, seen_q[k].y, want_q[k].y);
            check({tag, "_size"}, seen_q[k].s, want_q[k].s);
        end
    endtask

    initial begin : stim
        int n;
        int len;
        int sz;
        int r;
        repeat (3) @(negedge clock);
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(done), 0);
        check("rst_clipped", longint'(clipped), 0);
        check("rst_enable", longint'(char_enable), 0);
        check("rst_out", longint'({char_code, char_x, char_y, char_size}), 0);
        reset_n = 1'b1;

        load("AB");
        run_job("ab", 2, 10, 20, 2, 3, 1'b1);
        if (seen_q.size() == 2) begin
            check("ab_x0", seen_q[0].x, 10);
            check("ab_x1", seen_q[1].x, 22);
            check("ab_c1", seen_q[1].code, 8'h42);
        end
        run_job("ab_again", 2, 10, 20, 2, 1, 1'b0);

        load("A\nB");
        run_job("nl", 3, 0, 0, 1, 2, 1'b0);
        if (seen_q.size() == 2)
            check("nl_y1", seen_q[1].y, 8);

        for (int k = 0; k < 12; k++)
            shadow[k] = "X";
        write_shadow(12);
        run_job("wrap", 12, 600, 0, 1, 1, 1'b0);
        if (seen_q.size() == 12) begin
            check("wrap_last_x", seen_q[5].x, 630);
            check("wrap_next_x", seen_q[6].x, 600);
            check("wrap_next_y", seen_q[6].y, 8);
        end

        load("AB");
        run_job("clip", 2, 0, 430, 8, 2, 1'b0);
        run_job("len0", 0, 0, 0, 1, 2, 1'b0);
        run_job("size0", 2, 0, 0, 0, 2, 1'b0);

        load("A B");
        run_job("space", 3, 0, 0, 1, 2, 1'b0);
        if (seen_q.size() >= 2)
            check("space_x_last", seen_q[seen_q.size() - 1].x, 12);

        load("AB");
        rend_lat = 1000;
        @(negedge clock);
        length = LEN_W'(2);
        origin_x = '0;
        origin_y = '0;
        size = SIZE_W'(1);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n = 0;
        while (!char_enable && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("mid_draw", longint'(char_enable), 1);
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_enable", longint'(char_enable), 0);
        check("mid_rst_busy", longint'(busy), 0);
        check("mid_rst_done", longint'(done), 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        load("A");
        run_job("after_rst", 1, 0, 0, 1, 2, 1'b0);

        for (int t = 0; t < 30; t++) begin
            len = $urandom_range(1, MAX_CHARS);
            if (t == 7) len = 0;
            sz = $urandom_range(1, 4);
            if (t == 11) sz = $urandom_range(5, 15);
            for (int k = 0; k < len; k++) begin
                r = $urandom_range(0, 9);
                if (r == 0) shadow[k] = 8'h0A;
                else if (r == 1) shadow[k] = 8'h20;
                else shadow[k] = 8'(65 + $urandom_range(0, 25));
            end
            write_shadow(len);
            run_job("rand", len, $urandom_range(0, 640 - 5 * sz),
                    $urandom_range(0, 470), sz, $urandom_range(1, 4), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
